// File: rtl/flopr_rr_ctrl_if.sv
// rtl/flopr_rr_ctrl_if.sv - requester-side bundle for the round-robin shared-register controller
interface flopr_rr_ctrl_if #(
  parameter int N = 4,
  parameter int W = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [IW-1:0]  owner;
  logic           busy;
  logic           done;
  logic [W-1:0]   q;

  modport master (
    output req, wdata,
    input  gnt, owner, busy, done, q
  );

  modport slave (
    input  req, wdata,
    output gnt, owner, busy, done, q
  );
endinterface

// File: rtl/flopr_rr_ctrl.sv
// rtl/flopr_rr_ctrl.sv - round-robin write controller owning a shared W-bit register
module flopr_rr_ctrl #(
  parameter int N           = 4,
  parameter int W           = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  flopr_rr_ctrl_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_INIT = (HOLD_CYCLES > 0) ? CW'(HOLD_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  gnt;
  logic [IW-1:0] owner;
  logic [IW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic [W-1:0]  q;
  logic          done;

  logic          busy;
  logic          grant_en;
  logic          load_en;
  logic          release_en;
  logic          found;
  logic [IW-1:0] winner;
  logic [IW-1:0] idx;

  // Rotating priority search starting at ptr; first asserted request wins.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx    = '0;
    for (int o = 0; o < N; o++) begin
      idx = IW'((int'(ptr) + o) % N);
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = LOAD;
      LOAD:    state_nxt = (HOLD_CYCLES == 0) ? IDLE : HOLD;
      HOLD:    if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    grant_en   = (state == IDLE) && found;
    load_en    = (state == LOAD);
    release_en = (state != IDLE) && (state_nxt == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt   <= '0;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
      q     <= '0;
      done  <= 1'b0;
    end else begin
      done <= load_en;
      if (grant_en) begin
        gnt   <= N'(1) << winner;
        owner <= winner;
      end else if (release_en) begin
        gnt <= '0;
      end
      // Load is committed once granted, regardless of req[owner] now.
      if (load_en) begin
        q   <= bus.wdata[owner*W +: W];
        ptr <= (owner == IW'(N - 1)) ? '0 : owner + 1'b1;
        cnt <= HOLD_INIT;
      end else if (state == HOLD && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign bus.gnt   = gnt;
  assign bus.owner = owner;
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.q     = q;
endmodule

// File: tb/tb_flopr_rr_ctrl.sv
// tb/tb_flopr_rr_ctrl.sv - randomized self-checking bench for flopr_rr_ctrl (HOLD_CYCLES 2 and 0)
module tb_flopr_rr_ctrl;
  localparam int N = 4;
  localparam int W = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] wdata = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  flopr_rr_ctrl_if #(.N(N), .W(W)) bus_a ();
  flopr_rr_ctrl_if #(.N(N), .W(W)) bus_b ();

  assign bus_a.req   = req;
  assign bus_a.wdata = wdata;
  assign bus_b.req   = req;
  assign bus_b.wdata = wdata;

  flopr_rr_ctrl #(.N(N), .W(W), .HOLD_CYCLES(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  flopr_rr_ctrl #(.N(N), .W(W), .HOLD_CYCLES(0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  always #5 clk = ~clk;

  // Transaction-level reference: age counts edges since the grant edge, -1 when free.
  int hold [2] = '{2, 0};
  int m_age [2];
  int m_owner [2];
  int m_ptr [2];
  int m_q [2];
  int m_done [2];

  int ga [$];
  int gb [$];
  int ta [$];
  int tb_t [$];
  int qa [$];
  int done_b_cnt;
  logic [3:0] prev_a, prev_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_age[d] = -1; m_owner[d] = 0; m_ptr[d] = 0; m_q[d] = 0; m_done[d] = 0;
    end
  endtask

  task automatic model_step(input int d);
    int i;
    bit got;
    m_done[d] = 0;
    if (m_age[d] < 0) begin
      got = 0;
      for (int o = 0; o < N; o++) begin
        i = (m_ptr[d] + o) % N;
        if (!got && req[i]) begin
          got = 1;
          m_owner[d] = i;
        end
      end
      if (got) m_age[d] = 0;
    end else begin
      m_age[d]++;
      if (m_age[d] == 1) begin
        m_q[d] = (wdata >> (W * m_owner[d])) & 16'hF;
        m_ptr[d] = (m_owner[d] + 1) % N;
        m_done[d] = 1;
      end
      if (m_age[d] == 1 + hold[d]) m_age[d] = -1;
    end
  endtask

  function automatic logic [31:0] exp_gnt(input int d);
    return (m_age[d] >= 0) ? (32'd1 << m_owner[d]) : 32'd0;
  endfunction

  task automatic compare_all();
    check("a.gnt",   32'(bus_a.gnt),   exp_gnt(0));
    check("a.owner", 32'(bus_a.owner), 32'(m_owner[0]));
    check("a.busy",  32'(bus_a.busy),  32'(m_age[0] >= 0));
    check("a.done",  32'(bus_a.done),  32'(m_done[0]));
    check("a.q",     32'(bus_a.q),     32'(m_q[0]));
    check("b.gnt",   32'(bus_b.gnt),   exp_gnt(1));
    check("b.owner", 32'(bus_b.owner), 32'(m_owner[1]));
    check("b.busy",  32'(bus_b.busy),  32'(m_age[1] >= 0));
    check("b.done",  32'(bus_b.done),  32'(m_done[1]));
    check("b.q",     32'(bus_b.q),     32'(m_q[1]));
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    if (!reset) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
    #1;
    compare_all();
    if (prev_a == 0 && bus_a.gnt != 0) begin ga.push_back(int'(bus_a.gnt)); ta.push_back(cyc); end
    if (prev_b == 0 && bus_b.gnt != 0) begin gb.push_back(int'(bus_b.gnt)); tb_t.push_back(cyc); end
    if (bus_a.done) qa.push_back(int'(bus_a.q));
    if (bus_b.done) done_b_cnt++;
    prev_a = bus_a.gnt;
    prev_b = bus_b.gnt;
  endtask

  task automatic clear_logs();
    ga.delete(); gb.delete(); ta.delete(); tb_t.delete(); qa.delete();
    done_b_cnt = 0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    #1;
    reset = 1'b1;
    prev_a = '0;
    prev_b = '0;
  endtask

  initial begin
    int exp_seq3 [5] = '{1, 2, 4, 8, 1};
    int exp_q3 [5]   = '{1, 2, 3, 4, 1};
    int exp_seq6 [4] = '{1, 2, 1, 2};

    model_reset();
    prev_a = '0;
    prev_b = '0;

    // 1: held in reset with random inputs, then released with req idle
    for (int k = 0; k < 5; k++) begin
      req = 4'($urandom);
      wdata = 16'($urandom);
      cycle();
    end
    check("rst.gnt", 32'(bus_a.gnt), 32'd0);
    check("rst.q",   32'(bus_a.q),   32'd0);
    req = '0;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    check("idle.busy", 32'(bus_a.busy), 32'd0);

    // 2: single request latency
    req = 4'b0001; wdata = 16'h000F;
    cycle();
    check("t2.gnt_k", 32'(bus_a.gnt), 32'h1);
    check("t2.busy_k", 32'(bus_a.busy), 32'd1);
    cycle();
    check("t2.q_k1", 32'(bus_a.q), 32'hF);
    check("t2.done_k1", 32'(bus_a.done), 32'd1);
    req = '0;
    cycle();
    check("t2.done_k2", 32'(bus_a.done), 32'd0);
    cycle();
    check("t2.gnt_k3", 32'(bus_a.gnt), 32'd0);
    check("t2.busy_k3", 32'(bus_a.busy), 32'd0);

    // 3: all requesters, rotation, period, q sequence
    pulse_reset();
    clear_logs();
    req = 4'b1111; wdata = 16'h4321;
    for (int k = 0; k < 22; k++) cycle();
    check("t3.ngrants", 32'(ga.size() >= 5), 32'd1);
    for (int k = 0; k < 5 && k < ga.size(); k++) check("t3.gnt_order", 32'(ga[k]), 32'(exp_seq3[k]));
    for (int k = 0; k < 5 && k < qa.size(); k++) check("t3.q_order", 32'(qa[k]), 32'(exp_q3[k]));
    for (int k = 1; k < 5 && k < ta.size(); k++) check("t3.period", 32'(ta[k] - ta[k-1]), 32'd4);

    // 4: pointer sits at 2 after serving 1, then wraps
    pulse_reset();
    req = 4'b0010;
    cycle();
    req = '0;
    for (int k = 0; k < 4; k++) cycle();
    clear_logs();
    req = 4'b1010;
    for (int k = 0; k < 10; k++) cycle();
    check("t4.ngrants", 32'(ga.size() >= 2), 32'd1);
    if (ga.size() >= 2) begin
      check("t4.first", 32'(ga[0]), 32'h8);
      check("t4.second", 32'(ga[1]), 32'h2);
    end

    // 5: asynchronous reset in the middle of HOLD
    pulse_reset();
    req = 4'b0001; wdata = 16'h0007;
    cycle(); cycle(); cycle();
    check("t5.in_hold", 32'(bus_a.busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t5.async_gnt", 32'(bus_a.gnt), 32'd0);
    check("t5.async_q", 32'(bus_a.q), 32'd0);
    check("t5.async_busy", 32'(bus_a.busy), 32'd0);
    model_reset();
    req = '0;
    cycle();
    reset = 1'b1;
    prev_a = '0; prev_b = '0;
    req = 4'b0100;
    cycle();
    check("t5.regrant", 32'(bus_a.gnt), 32'h4);

    // 6: zero hold, two requesters alternate every two cycles
    pulse_reset();
    clear_logs();
    req = 4'b0011; wdata = 16'h00A5;
    for (int k = 0; k < 8; k++) cycle();
    check("t6.ngrants", 32'(gb.size() >= 4), 32'd1);
    for (int k = 0; k < 4 && k < gb.size(); k++) check("t6.gnt_order", 32'(gb[k]), 32'(exp_seq6[k]));
    for (int k = 1; k < 4 && k < tb_t.size(); k++) check("t6.period", 32'(tb_t[k] - tb_t[k-1]), 32'd2);
    check("t6.done_count", 32'(done_b_cnt), 32'd4);

    // Random soak, including occasional resets between edges
    for (int k = 0; k < 400; k++) begin
      req = 4'($urandom);
      wdata = 16'($urandom);
      reset = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
      if (!reset) begin
        #1;
        check("soak.async_gnt_a", 32'(bus_a.gnt), 32'd0);
        model_reset();
        prev_a = '0; prev_b = '0;
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
